cook_operator: RTL
==================

Name: cook_operator

Overview:
- Drives the `temp`/`flip` side of the cook status FSM, which has a `need_flip` output and a 2-bit `status`.
- Runs one batch per `start`:
  - pulses a restart into the cook FSM,
  - waits a programmable heating time,
  - issues the temp pulse and then the flip pulse at the single cycle the cook FSM accepts them,
  - grades the result.
- Sits beside the cook FSM. The `temp`/`flip`/`cook_rst` outputs of this block connect directly to that FSM's `temp`/`flip`/`reset` inputs.

Parameters:
- HEAT_CYCLES, 3, cycles spent in HEAT before the temp pulse; legal range 1..255.
- CNT_W, 8, width of the ok/fail batch counters.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin a batch; sampled only in IDLE.
- status  input  2  cook FSM status: 00 raw, 01 ready-to-flip, 10 flipped-good, 11 finished/terminal.
- need_flip  input  1  cook FSM flip request; high iff status==01.
- temp  output  1  temperature-reached pulse to the cook FSM.
- flip  output  1  flip pulse to the cook FSM.
- cook_rst  output  1  one-cycle restart pulse into the cook FSM reset.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse marking batch end.
- last_ok  output  1  grade of the most recent batch.
- ok_cnt  output  CNT_W  count of good batches, saturating.
- fail_cnt  output  CNT_W  count of failed batches, saturating.

Behaviour:
- Reset:
  - asynchronous, active-high;
  - state=IDLE;
  - all outputs 0, including counters and last_ok.
- Output timing:
  - all outputs come from flops or from the state register only;
  - no combinational path from inputs to outputs.
- FSM states and transitions; "cycle Cn" means n cycles after the edge that samples start:
  - IDLE: busy=0. If start=1 at an edge, go to CLEAR. If start=1 in any other state, ignore it.
  - CLEAR (C1): cook_rst=1 for exactly one cycle. Load the heat timer with HEAT_CYCLES. Go to HEAT.
  - HEAT (C2..C1+HEAT_CYCLES): temp=0, flip=0. Every cycle, require status==00.
    - If status!=00, go to CHECK with a fail flag set.
    - Otherwise, when the timer reaches its terminal count, go to TEMP.
  - TEMP (C2+H): temp=1, flip=0. The cook FSM moves 00→01 at the closing edge. Go to FLIP.
  - FLIP (C3+H): temp=0, flip=1. Latch need_flip; if need_flip=0, set the fail flag. Go to CHECK.
  - CHECK (C4+H): pass iff the fail flag is clear AND status==10.
    - Update last_ok.
    - Increment ok_cnt or fail_cnt; the new value is visible in the DONE cycle.
    - Go to DONE.
  - DONE (C5+H): done=1 for one cycle. Go to IDLE.
- Timing of a clean batch: exactly 5+HEAT_CYCLES cycles from the start edge to the done pulse.
- temp and flip:
  - are never both high in the same cycle;
  - are each high for at most one cycle per batch.
- An aborted batch (fault detected in HEAT) never asserts temp or flip.
- Counters:
  - saturate at 2^CNT_W−1;
  - a saturated counter holds its value while last_ok and done still update.
- The fail flag clears on entry to CLEAR.
- Reset mid-batch: return to IDLE immediately. Any outstanding temp/flip/cook_rst drops the same instant, because reset is asynchronous.
- Status 11 seen during HEAT (cook FSM stuck or flipped early): fail.

Decomposition:
- Shared package cook_pkg holds:
  - status encodings ST_RAW=2'b00, ST_READY=2'b01, ST_GOOD=2'b10, ST_END=2'b11;
  - the operator state encoding: IDLE, CLEAR, HEAT, TEMP, FLIP, CHECK, DONE.
- One sub-module, heat_timer:
  - 8-bit loadable down-counter;
  - inputs load, value, en;
  - output tc, asserted when the count equals 1 while enabled.

Test Plan:
- Clean batch: HEAT_CYCLES=3, real cook FSM attached, start pulse at C0.
  - Required: cook_rst at C1, temp at C5, flip at C6, status=10 at C7, done and last_ok=1 at C8, ok_cnt=1.
- Stuck cook: status forced to 11 with no cook FSM attached, start.
  - Required: fail detected at C2, no temp and no flip ever, done at C4, last_ok=0, fail_cnt=1.
- Missing need_flip: status held at 00 and need_flip held at 0, start.
  - Required: temp at C5, flip at C6, done at C8 with last_ok=0, fail_cnt=1.
- Start while busy: start held high for 10 cycles.
  - Required: exactly one batch per IDLE visit; the second batch's cook_rst occurs the cycle after the first batch's IDLE.
- Async reset at C5 (during TEMP), deasserted between edges.
  - Required: temp drops immediately, busy=0, counters=0; a following start yields a clean batch.
- Saturation: CNT_W=2, run 5 good batches.
  - Required: ok_cnt stays at 3 after the third batch; done still pulses each batch.

Source files
------------

// File: rtl/cook_pkg.sv
// -----------------------------------------------------------------------------
// cook_pkg
// Shared definitions for the cook operator slice:
//   - cook FSM status encodings (what the cook FSM reports back)
//   - operator FSM state encoding
//   - batch grading helper
// No ports (package).
// -----------------------------------------------------------------------------
package cook_pkg;

  // Status reported by the cook FSM.
  typedef enum logic [1:0] {
    ST_RAW   = 2'b00,
    ST_READY = 2'b01,
    ST_GOOD  = 2'b10,
    ST_END   = 2'b11
  } cook_status_e;

  // Operator FSM states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    HEAT  = 3'd2,
    TEMP  = 3'd3,
    FLIP  = 3'd4,
    CHECK = 3'd5,
    DONE  = 3'd6
  } op_state_e;

  localparam int TIMER_W = 8;

  // A batch is good only if nothing went wrong on the way and the cook FSM
  // ended up in the flipped-good state.
  function automatic logic batch_pass(input logic fail, input logic [1:0] status);
    return (!fail) && (status == ST_GOOD);
  endfunction

endpackage

// File: rtl/cook_operator_heat_timer.sv
// -----------------------------------------------------------------------------
// heat_timer
// 8-bit loadable down-counter that times the HEAT phase.
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous active-high reset
//   load_i   in   load value_i into the counter
//   value_i  in   8-bit load value
//   en_i     in   count down one step per cycle
//   tc_o     out  terminal count: counter equals 1 while enabled
// -----------------------------------------------------------------------------
module heat_timer
  import cook_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] value_i,
  input  logic               en_i,
  output logic               tc_o
);

  logic [TIMER_W-1:0] count_q;
  logic [TIMER_W-1:0] count_d;

  // Next count: load has priority; the counter parks at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = value_i;
    end else if (en_i && (count_q != 8'd0)) begin
      count_d = count_q - 8'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  // Count==1 is the last HEAT cycle, so the FSM can leave on this edge.
  assign tc_o = en_i && (count_q == 8'd1);

endmodule

// File: rtl/cook_operator.sv
// -----------------------------------------------------------------------------
// cook_operator
// Runs one cook batch per start: restarts the cook FSM, heats for
// HEAT_CYCLES cycles, issues temp then flip, and grades the outcome.
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   start      in   begin a batch (only honoured in IDLE)
//   status     in   2-bit cook FSM status
//   need_flip  in   cook FSM flip request
//   temp       out  temperature-reached pulse to the cook FSM
//   flip       out  flip pulse to the cook FSM
//   cook_rst   out  one-cycle restart pulse to the cook FSM
//   busy       out  high outside IDLE
//   done       out  one-cycle end-of-batch pulse
//   last_ok    out  grade of the most recent batch
//   ok_cnt     out  saturating count of good batches
//   fail_cnt   out  saturating count of failed batches
// All outputs are flops; none depends combinationally on an input.
// -----------------------------------------------------------------------------
module cook_operator
  import cook_pkg::*;
#(
  parameter int HEAT_CYCLES = 3,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       status,
  input  logic             need_flip,
  output logic             temp,
  output logic             flip,
  output logic             cook_rst,
  output logic             busy,
  output logic             done,
  output logic             last_ok,
  output logic [CNT_W-1:0] ok_cnt,
  output logic [CNT_W-1:0] fail_cnt
);

  localparam logic [TIMER_W-1:0] HEAT_LOAD = TIMER_W'(HEAT_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};

  op_state_e        state_q, state_d;
  logic             fail_q, fail_d;
  logic             last_ok_q, last_ok_d;
  logic [CNT_W-1:0] ok_cnt_q, ok_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic             temp_q, flip_q, cook_rst_q, busy_q, done_q;
  logic             timer_load_s, timer_en_s, timer_tc_s;
  logic             pass_s;

  heat_timer u_heat_timer (
    .clk     (clk),
    .reset   (reset),
    .load_i  (timer_load_s),
    .value_i (HEAT_LOAD),
    .en_i    (timer_en_s),
    .tc_o    (timer_tc_s)
  );

  // Next-state, fail flag, grade and counter logic.
  always_comb begin
    state_d      = state_q;
    fail_d       = fail_q;
    last_ok_d    = last_ok_q;
    ok_cnt_d     = ok_cnt_q;
    fail_cnt_d   = fail_cnt_q;
    timer_load_s = 1'b0;
    timer_en_s   = 1'b0;
    pass_s       = batch_pass(fail_q, status);
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLEAR;
          fail_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      CLEAR: begin
        timer_load_s = 1'b1;
        state_d      = HEAT;
      end
      HEAT: begin
        timer_en_s = 1'b1;
        // A fault wins over terminal count: an aborted batch must never
        // reach TEMP or FLIP.
        if (status != ST_RAW) begin
          fail_d  = 1'b1;
          state_d = CHECK;
        end else if (timer_tc_s) begin
          state_d = TEMP;
        end else begin
          state_d = HEAT;
        end
      end
      TEMP: begin
        state_d = FLIP;
      end
      FLIP: begin
        if (!need_flip) begin
          fail_d = 1'b1;
        end else begin
          fail_d = fail_q;
        end
        state_d = CHECK;
      end
      CHECK: begin
        last_ok_d = pass_s;
        if (pass_s) begin
          if (ok_cnt_q != CNT_MAX) begin
            ok_cnt_d = ok_cnt_q + CNT_ONE;
          end else begin
            ok_cnt_d = ok_cnt_q;
          end
        end else begin
          if (fail_cnt_q != CNT_MAX) begin
            fail_cnt_d = fail_cnt_q + CNT_ONE;
          end else begin
            fail_cnt_d = fail_cnt_q;
          end
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and batch bookkeeping registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      fail_q     <= 1'b0;
      last_ok_q  <= 1'b0;
      ok_cnt_q   <= {CNT_W{1'b0}};
      fail_cnt_q <= {CNT_W{1'b0}};
    end else begin
      state_q    <= state_d;
      fail_q     <= fail_d;
      last_ok_q  <= last_ok_d;
      ok_cnt_q   <= ok_cnt_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  // Output flops: decoded from the next state so each is high exactly while
  // the FSM sits in the matching state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      temp_q     <= 1'b0;
      flip_q     <= 1'b0;
      cook_rst_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      temp_q     <= (state_d == TEMP);
      flip_q     <= (state_d == FLIP);
      cook_rst_q <= (state_d == CLEAR);
      busy_q     <= (state_d != IDLE);
      done_q     <= (state_d == DONE);
    end
  end

  assign temp     = temp_q;
  assign flip     = flip_q;
  assign cook_rst = cook_rst_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign last_ok  = last_ok_q;
  assign ok_cnt   = ok_cnt_q;
  assign fail_cnt = fail_cnt_q;

endmodule
